// File: rtl/pkg_mips.sv
// Shared MIPS pipeline definitions: datapath widths, the hard-wired zero register
// and the write-back source selection.
package pkg_mips;

  localparam int LARGURA   = 32;
  localparam int NREG_BITS = 5;

  localparam logic [NREG_BITS-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_t;

  // Link (jal) takes precedence over a memory load.
  function automatic wb_sel_t wb_select(input logic link, input logic mem_to_reg);
    if (link) begin
      return WB_LINK;
    end else if (mem_to_reg) begin
      return WB_MEM;
    end
    return WB_ALU;
  endfunction

endpackage

// File: rtl/estagio_mem_wb.sv
// MEM/WB pipeline register with write-back source select, register-file write port,
// forwarding bus back to EX and retired/bubble performance counters.
module estagio_mem_wb
  import pkg_mips::*;
#(
  parameter int LARGURA   = pkg_mips::LARGURA,
  parameter int NREG_BITS = pkg_mips::NREG_BITS,
  parameter int CONT_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [LARGURA-1:0]   dado_mem,
  input  logic [LARGURA-1:0]   resultado_alu,
  input  logic [LARGURA-1:0]   pc_mais4,
  input  logic                 MemToReg,
  input  logic                 Link,
  input  logic                 RegWrite,
  input  logic [NREG_BITS-1:0] reg_dest,
  output logic                 wb_RegWrite,
  output logic [NREG_BITS-1:0] wb_reg_dest,
  output logic [LARGURA-1:0]   wb_dado,
  output logic                 fwd_valid,
  output logic [NREG_BITS-1:0] fwd_reg,
  output logic [LARGURA-1:0]   fwd_dado,
  output logic [CONT_BITS-1:0] cont_retirado,
  output logic [CONT_BITS-1:0] cont_bolha
);

  logic                 valid_reg;
  logic                 reg_write_reg;
  logic [NREG_BITS-1:0] reg_dest_reg;
  logic [LARGURA-1:0]   dado_reg;
  logic [CONT_BITS-1:0] cont_retirado_reg;
  logic [CONT_BITS-1:0] cont_bolha_reg;

  wb_sel_t              sel;
  logic [LARGURA-1:0]   dado_next;

  // The write-back source is resolved before capture so the output path is a flop.
  always_comb begin
    sel       = wb_select(Link, MemToReg);
    dado_next = resultado_alu;
    case (sel)
      WB_LINK: dado_next = pc_mais4;
      WB_MEM:  dado_next = dado_mem;
      WB_ALU:  dado_next = resultado_alu;
      default: dado_next = resultado_alu;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg         <= 1'b0;
      reg_write_reg     <= 1'b0;
      reg_dest_reg      <= '0;
      dado_reg          <= '0;
      cont_retirado_reg <= '0;
      cont_bolha_reg    <= '0;
    end else if (flush) begin
      // Squashed instruction is dropped without being counted; data fields are held.
      valid_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg     <= in_valid;
      reg_write_reg <= RegWrite;
      reg_dest_reg  <= reg_dest;
      dado_reg      <= dado_next;
      // Counters classify the slot being vacated, so a retirement is seen one edge later.
      if (valid_reg) begin
        cont_retirado_reg <= cont_retirado_reg + CONT_BITS'(1);
      end else begin
        cont_bolha_reg <= cont_bolha_reg + CONT_BITS'(1);
      end
    end
  end

  assign wb_RegWrite   = valid_reg & reg_write_reg & (reg_dest_reg != NREG_BITS'(REG_ZERO));
  assign wb_reg_dest   = reg_dest_reg;
  assign wb_dado       = dado_reg;
  assign fwd_valid     = wb_RegWrite;
  assign fwd_reg       = reg_dest_reg;
  assign fwd_dado      = dado_reg;
  assign cont_retirado = cont_retirado_reg;
  assign cont_bolha    = cont_bolha_reg;

endmodule

// File: tb/tb_estagio_mem_wb.sv
// Directed self-checking bench for estagio_mem_wb: write-back select, $zero suppression,
// stall/flush priority, asynchronous reset, counter totals and 4-bit counter wrap.
module tb_estagio_mem_wb;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, stall, flush;
  logic [31:0] dado_mem, resultado_alu, pc_mais4;
  logic        MemToReg, Link, RegWrite;
  logic [4:0]  reg_dest;

  logic        wb_RegWrite, fwd_valid;
  logic [4:0]  wb_reg_dest, fwd_reg;
  logic [31:0] wb_dado, fwd_dado, cont_retirado, cont_bolha;

  logic        s_wb_RegWrite, s_fwd_valid;
  logic [4:0]  s_wb_reg_dest, s_fwd_reg;
  logic [31:0] s_wb_dado, s_fwd_dado;
  logic [3:0]  s_cont_retirado, s_cont_bolha;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_valid;
  logic [31:0] exp_ret, exp_bol;
  logic [31:0] base_ret, base_bol;

  always #5 clock = ~clock;

  estagio_mem_wb dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .dado_mem(dado_mem), .resultado_alu(resultado_alu), .pc_mais4(pc_mais4),
    .MemToReg(MemToReg), .Link(Link), .RegWrite(RegWrite), .reg_dest(reg_dest),
    .wb_RegWrite(wb_RegWrite), .wb_reg_dest(wb_reg_dest), .wb_dado(wb_dado),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_dado(fwd_dado),
    .cont_retirado(cont_retirado), .cont_bolha(cont_bolha)
  );

  estagio_mem_wb #(.CONT_BITS(4)) dut_small (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .dado_mem(dado_mem), .resultado_alu(resultado_alu), .pc_mais4(pc_mais4),
    .MemToReg(MemToReg), .Link(Link), .RegWrite(RegWrite), .reg_dest(reg_dest),
    .wb_RegWrite(s_wb_RegWrite), .wb_reg_dest(s_wb_reg_dest), .wb_dado(s_wb_dado),
    .fwd_valid(s_fwd_valid), .fwd_reg(s_fwd_reg), .fwd_dado(s_fwd_dado),
    .cont_retirado(s_cont_retirado), .cont_bolha(s_cont_bolha)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m2r, input logic lnk, input logic rw,
                       input logic [4:0] rd, input logic [31:0] dm, input logic [31:0] alu,
                       input logic [31:0] pc);
    in_valid = v; MemToReg = m2r; Link = lnk; RegWrite = rw; reg_dest = rd;
    dado_mem = dm; resultado_alu = alu; pc_mais4 = pc; stall = 1'b0; flush = 1'b0;
  endtask

  // Counter reference: account for the slot vacated at the coming edge, then advance it.
  task automatic step();
    if (!flush && !stall) begin
      if (exp_valid) exp_ret = exp_ret + 1;
      else           exp_bol = exp_bol + 1;
    end
    if (flush)       exp_valid = 1'b0;
    else if (!stall) exp_valid = in_valid;
    @(posedge clock);
    #1;
    $display("t=%0t v=%0b st=%0b fl=%0b -> wb_we=%0b rd=%0d dado=%08h ret=%0d bol=%0d",
             $time, in_valid, stall, flush, wb_RegWrite, wb_reg_dest, wb_dado,
             cont_retirado, cont_bolha);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ret"}, cont_retirado, exp_ret);
    check({tag, "_bol"}, cont_bolha, exp_bol);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_we"},   wb_RegWrite, 0);
    check({tag, "_rd"},   wb_reg_dest, 0);
    check({tag, "_dado"}, wb_dado, 0);
    check({tag, "_fv"},   fwd_valid, 0);
    check({tag, "_ret"},  cont_retirado, 0);
    check({tag, "_bol"},  cont_bolha, 0);
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_ret = '0; exp_bol = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    model_reset();
    #3;
    check_cleared("reset_init");
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    // Load path: sign-extended memory word written back to r8
    drive(1, 1, 0, 1, 5'd8, 32'hFFFF8001, 32'h1234, 32'h200);
    step();
    check("load_we",   wb_RegWrite, 1);
    check("load_rd",   wb_reg_dest, 8);
    check("load_dado", wb_dado, 32'hFFFF8001);
    check("load_fv",   fwd_valid, 1);
    check("load_frd",  fwd_reg, 8);
    check("load_fdat", fwd_dado, 32'hFFFF8001);
    check_counts("load_cnt");

    drive(1, 0, 0, 1, 5'd3, 32'hDEAD0000, 32'h0000_0040, 32'h300);
    step();
    check("alu_dado", wb_dado, 32'h40);
    check("alu_rd",   wb_reg_dest, 3);

    drive(1, 1, 1, 1, 5'd31, 32'hBEEF0000, 32'h0000_0077, 32'h104);
    step();
    check("link_dado", wb_dado, 32'h104);
    check("link_fdat", fwd_dado, 32'h104);

    // $zero destination: no write, but still retires
    drive(1, 0, 0, 1, 5'd0, 32'h0, 32'h99, 32'h0);
    step();
    check("zero_we", wb_RegWrite, 0);
    check("zero_fv", fwd_valid, 0);
    base_ret = cont_retirado;
    drive(1, 0, 0, 1, 5'd9, 32'h0, 32'h55, 32'h0);
    step();
    check("zero_retired", cont_retirado, base_ret + 1);
    check_counts("zero_cnt");

    // Stall for 3 cycles with different inputs: everything frozen on r9 / 0x55
    drive(1, 1, 0, 1, 5'd12, 32'hAAAA, 32'hBBBB, 32'hCCCC);
    stall = 1'b1;
    base_ret = exp_ret; base_bol = exp_bol;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_we",   wb_RegWrite, 1);
      check("stall_rd",   wb_reg_dest, 9);
      check("stall_dado", wb_dado, 32'h55);
      check("stall_ret",  cont_retirado, base_ret);
      check("stall_bol",  cont_bolha, base_bol);
    end

    // Stall and flush together: flush wins, r9 never retires
    flush = 1'b1;
    step();
    check("flush_we",  wb_RegWrite, 0);
    check("flush_fv",  fwd_valid, 0);
    check("flush_ret", cont_retirado, base_ret);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    check("postflush_ret", cont_retirado, base_ret);
    check("postflush_bol", cont_bolha, base_bol + 1);

    // 10 valid then 4 idle unstalled cycles
    base_ret = cont_retirado; base_bol = cont_bolha;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 1, 5'(i + 1), 32'h0, 32'(i * 3), 32'h0);
      step();
    end
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("cnt10_ret", cont_retirado - base_ret, 10);
    check("cnt4_bol",  cont_bolha - base_bol, 4);
    check_counts("cnt_model");

    // Asynchronous reset in the middle of a stall
    drive(1, 0, 0, 1, 5'd7, 32'h0, 32'h1111, 32'h0);
    step();
    check("prereset_we", wb_RegWrite, 1);
    stall = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_cleared("reset_stall");
    @(posedge clock); #1;
    check_cleared("reset_hold");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Counter wrap on the 4-bit build
    for (int i = 0; i < 18; i++) begin
      drive(1, 0, 0, 1, 5'd4, 32'h0, 32'(i), 32'h0);
      step();
      check("small_ret", s_cont_retirado, exp_ret[3:0]);
      if (exp_ret == 32'd16) check("small_wrap", s_cont_retirado, 0);
    end
    check_counts("wrap_big");
    check("small_bol", s_cont_bolha, exp_bol[3:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
